// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - arbitrates L1 I/D line misses onto a single L2 port
// One L2 transaction outstanding; request fields captured at grant, response routed back combinationally.
module l1_l2_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int LINE_WIDTH     = 128,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  state_t state;
  logic   last_grant_d;
  logic   d_req;
  logic   grant_d;
  logic   fixed_d;

  assign fixed_d = (FIXED_PRIORITY != 0);
  assign d_req   = d_read | d_write;
  // D wins when alone, under fixed priority, or when I was served last.
  assign grant_d = d_req & (~i_read | fixed_d | ~last_grant_d);

  assign i_resp  = (state == BUSY_I) & l2_resp;
  assign d_resp  = (state == BUSY_D) & l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      l2_read      <= 1'b0;
      l2_write     <= 1'b0;
      l2_address   <= '0;
      l2_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read | d_req) begin
            if (grant_d) begin
              state      <= BUSY_D;
              l2_address <= d_address;
              l2_wdata   <= d_wdata;
              // A simultaneous read and write is treated as a writeback.
              l2_write   <= d_write;
              l2_read    <= ~d_write;
            end else begin
              state      <= BUSY_I;
              l2_address <= i_address;
              l2_wdata   <= '0;
              l2_write   <= 1'b0;
              l2_read    <= 1'b1;
            end
          end
        end
        BUSY_I: begin
          if (l2_resp) begin
            l2_read      <= 1'b0;
            l2_write     <= 1'b0;
            last_grant_d <= 1'b0;
            state        <= RELEASE;
          end
        end
        BUSY_D: begin
          if (l2_resp) begin
            l2_read      <= 1'b0;
            l2_write     <= 1'b0;
            last_grant_d <= 1'b1;
            state        <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
